// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel level synchroniser.
//   SYNC_MIN_STAGES            : shortest legal synchroniser chain
//   SYNC_DEFAULT_FILTER_CYCLES : default stability window of the optional glitch filter
//   clog2_cnt(n)               : width of a counter that must hold values 0..n
package sync_pkg;

  localparam int SYNC_MIN_STAGES            = 2;
  localparam int SYNC_DEFAULT_FILTER_CYCLES = 4;

  // Never returns less than 1 so a degenerate window still yields a legal vector.
  function automatic int clog2_cnt(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_chan.sv
// One channel of the level synchroniser: STAGES-flop chain, optional glitch
// filter, previous-level flop and registered-edge pulses.
// Optional feature: define SYNC_MULTI_CHAN_FILTER_EN to build the glitch filter.
// Ports:
//   clk        : sampling clock
//   rst_n      : asynchronous active-low reset
//   async_in   : asynchronous level input
//   sync_out   : synchronised (and, if built, filtered) level
//   rise_pulse : high for the single cycle in which sync_out went 0->1
//   fall_pulse : high for the single cycle in which sync_out went 1->0
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter logic RESET_VAL     = 1'b0,
  parameter int   FILTER_CYCLES = SYNC_DEFAULT_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_chan: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("sync_chan: FILTER_CYCLES must be >= 1");
  end

  // s[0] is the only flop allowed to go metastable; only s[STAGES-1] is read.
  logic [STAGES-1:0] s;
  logic              level;
  logic              prev;

  // NOTE: state is updated with non-blocking assignments and reset asynchronously,
  // so every flop in the chain sees the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= {STAGES{RESET_VAL}};
    else        s <= {s[STAGES-2:0], async_in};
  end

`ifdef SYNC_MULTI_CHAN_FILTER_EN
  localparam int CNT_W = clog2_cnt(FILTER_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             level_q;

  // The output only follows once the chain output has disagreed with it for
  // FILTER_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= RESET_VAL;
    end else if (s[STAGES-1] == level_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
      level_q <= s[STAGES-1];
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = level_q;
`else
  // The last chain flop is the output register: no extra latency.
  assign level = s[STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= level;
  end

  assign sync_out   = level;
  assign rise_pulse = level & ~prev;
  assign fall_pulse = ~level & prev;

endmodule

// File: rtl/sync_multi_chan.sv
// N-channel, M-stage synchroniser for asynchronous level inputs into clk.
// Channels are independent; not for multi-bit buses needing coherency.
// Optional feature: define SYNC_MULTI_CHAN_FILTER_EN to add a per-channel
// glitch filter (FILTER_CYCLES stable cycles) after each chain.
// Ports:
//   clk        : sampling clock
//   rst_n      : asynchronous active-low reset
//   async_in   : WIDTH asynchronous level inputs
//   sync_out   : WIDTH synchronised levels
//   rise_pulse : WIDTH single-cycle 0->1 pulses of sync_out
//   fall_pulse : WIDTH single-cycle 1->0 pulses of sync_out
//   any_change : OR of all rise/fall pulses
module sync_multi_chan
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter int               FILTER_CYCLES = SYNC_DEFAULT_FILTER_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_chan #(
      .STAGES        (STAGES),
      .RESET_VAL     (RESET_VAL[i]),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (async_in[i]),
      .sync_out   (sync_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_multi_chan.sv
// Directed self-checking bench for sync_multi_chan: a STAGES=2 instance (a_*)
// and a STAGES=3 instance (b_*). Latencies follow SYNC_MULTI_CHAN_FILTER_EN.
module tb_sync_multi_chan;

`ifdef SYNC_MULTI_CHAN_FILTER_EN
  localparam int LAT_A = 2 + 4;
  localparam int LAT_B = 3 + 4;
`else
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_in, a_sync, a_rise, a_fall;
  logic [7:0] b_in, b_sync, b_rise, b_fall;
  logic       a_any, b_any;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_multi_chan #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h00), .FILTER_CYCLES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .async_in(a_in), .sync_out(a_sync),
    .rise_pulse(a_rise), .fall_pulse(a_fall), .any_change(a_any)
  );

  sync_multi_chan #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00), .FILTER_CYCLES(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .async_in(b_in), .sync_out(b_sync),
    .rise_pulse(b_rise), .fall_pulse(b_fall), .any_change(b_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Input already driven just after a falling edge; expects the new level after
  // lat rising edges, a single-cycle pulse, then quiet.
  task automatic expect_a_step(input string tag, input int lat, input logic [7:0] old_v,
                               input logic [7:0] new_v);
    repeat (lat - 1) @(negedge clk);
    check({tag, "_before"}, a_sync, old_v);
    @(negedge clk);
    check({tag, "_sync"}, a_sync, new_v);
    check({tag, "_rise"}, a_rise, new_v & ~old_v);
    check({tag, "_fall"}, a_fall, ~new_v & old_v);
    check({tag, "_any"}, a_any, 1'b1);
    @(negedge clk);
    check({tag, "_rise_end"}, a_rise, 8'h00);
    check({tag, "_fall_end"}, a_fall, 8'h00);
    check({tag, "_any_end"}, a_any, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_in  = 8'hFF;
    b_in  = 8'h00;

    // Reset holds outputs at RESET_VAL with the inputs already high.
    repeat (2) @(negedge clk);
    check("rst_sync", a_sync, 8'h00);
    check("rst_rise", a_rise, 8'h00);
    check("rst_any", a_any, 1'b0);
    check("rst_b_sync", b_sync, 8'h00);
    #1 rst_n = 1'b1;
    expect_a_step("release", LAT_A, 8'h00, 8'hFF);

    // Single bit toggled mid-period.
    #1 a_in = 8'h00;
    repeat (LAT_A + 2) @(negedge clk);
    check("clear_sync", a_sync, 8'h00);
    #2 a_in = 8'h08;
    expect_a_step("bit3", LAT_A, 8'h00, 8'h08);

    // Simultaneous rise and fall on complementary channels.
    #1 a_in = 8'hA5;
    repeat (LAT_A + 2) @(negedge clk);
    check("a5_sync", a_sync, 8'hA5);
    #1 a_in = 8'h5A;
    expect_a_step("swap", LAT_A, 8'hA5, 8'h5A);

    // Three-stage instance: exact latency.
    #1 b_in = 8'h01;
    repeat (LAT_B - 1) @(negedge clk);
    check("b_before", b_sync, 8'h00);
    @(negedge clk);
    check("b_sync", b_sync, 8'h01);
    check("b_rise", b_rise, 8'h01);
    check("b_any", b_any, 1'b1);
    @(negedge clk);
    check("b_rise_end", b_rise, 8'h00);

    // Asynchronous reset mid-flight (filter counters part-way through).
    #1 a_in = 8'hFF;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_sync", a_sync, 8'h00);
    check("mid_rst_rise", a_rise, 8'h00);
    check("mid_rst_fall", a_fall, 8'h00);
    check("mid_rst_any", a_any, 1'b0);
    check("mid_rst_b_sync", b_sync, 8'h00);
    a_in = 8'h00;
    b_in = 8'h00;
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < LAT_B + 2; i++) begin
      @(negedge clk);
      check("post_rst_any", a_any, 1'b0);
      check("post_rst_b_any", b_any, 1'b0);
    end
    check("post_rst_sync", a_sync, 8'h00);

`ifdef SYNC_MULTI_CHAN_FILTER_EN
    // Three-cycle excursion is suppressed entirely.
    #1 a_in = 8'h02;
    repeat (3) @(negedge clk);
    #1 a_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("glitch_sync", a_sync, 8'h00);
      check("glitch_any", a_any, 1'b0);
    end

    // Five-cycle excursion passes after 2+4 edges with a single pulse.
    #1 a_in = 8'h02;
    repeat (5) @(negedge clk);
    check("long_before", a_sync, 8'h00);
    #1 a_in = 8'h00;
    @(negedge clk);
    check("long_sync", a_sync, 8'h02);
    check("long_rise", a_rise, 8'h02);
    @(negedge clk);
    check("long_rise_end", a_rise, 8'h00);
    check("long_hold", a_sync, 8'h02);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
